// File: rtl/irq_collector_if.sv
// Memory-mapped register bus shared with the timer devices.
// The CPU side drives address/write strobe/data; the device returns read data.
interface irq_collector_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport master (output Addr, output WE, output DataIn, input DataOut);
  modport slave  (input Addr, input WE, input DataIn, output DataOut);
endinterface : irq_collector_if

// File: rtl/irq_collector.sv
// Interrupt collector: latches device IRQ lines into pending flags, applies
// per-line mask and edge/level mode, and presents a registered HWInt vector
// and IntReq to CP0. Software sees PENDING (W1C), MASK, MODE and ID registers.
module irq_collector #(
  parameter int          N    = 6,
  parameter logic [31:0] BASE = 32'h0000_7f20
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  irq_collector_if.slave   bus,
  input  logic [N-1:0]     DevIRQ,
  output logic [5:0]       HWInt,
  output logic             IntReq
);

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_MASK    = 2'd1,
    REG_MODE    = 2'd2,
    REG_ID      = 2'd3
  } reg_idx_e;

  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] mask_q,    mask_d;
  logic [N-1:0] mode_q,    mode_d;
  logic [N-1:0] prev_q,    prev_d;
  logic [5:0]   hwint_q,   hwint_d;
  logic         intreq_q,  intreq_d;

  logic         sel;
  reg_idx_e     reg_idx;
  logic         wr_en;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] active_d;
  logic [N-1:0] id_cand;
  logic         id_valid;
  logic [2:0]   id_index;
  logic [31:0]  rd_data;
  logic         unused_bits;

  // Address bits below word granularity and data bits above N carry nothing.
  assign unused_bits = ^{bus.Addr[1:0], bus.DataIn[31:N]};

  // Decode, capture and next-state computation for all software-visible state.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    sel      = (bus.Addr[31:4] == BASE[31:4]);
    reg_idx  = reg_idx_e'(bus.Addr[3:2]);
    wr_en    = bus.WE && sel;
    clr_vec  = '0;
    mask_d   = mask_q;
    mode_d   = mode_q;

    // Edge lines fire on a rising transition, level lines whenever high.
    set_vec  = (mode_q & DevIRQ & ~prev_q) | (~mode_q & DevIRQ);

    if (wr_en) begin
      unique case (reg_idx)
        REG_PENDING: clr_vec = bus.DataIn[N-1:0];
        REG_MASK:    mask_d  = bus.DataIn[N-1:0];
        REG_MODE:    mode_d  = bus.DataIn[N-1:0];
        default:     ;  // ID is read-only
      endcase
    end

    // Set wins over a simultaneous software clear.
    pending_d = (pending_q & ~clr_vec) | set_vec;
    prev_d    = DevIRQ;

    active_d         = pending_d & mask_d;
    hwint_d          = '0;
    hwint_d[N-1:0]   = active_d;
    intreq_d         = |active_d;
  end

  // Priority encoder over the currently enabled pending lines; line 0 wins.
  always_comb begin
    id_cand  = pending_q & mask_q;
    id_valid = 1'b0;
    id_index = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (id_cand[i]) begin
        id_valid = 1'b1;
        id_index = i[2:0];
      end
    end
  end

  // Combinational read mux; anything outside the window reads zero.
  always_comb begin
    rd_data = '0;
    if (sel) begin
      unique case (reg_idx)
        REG_PENDING: rd_data[N-1:0] = pending_q;
        REG_MASK:    rd_data[N-1:0] = mask_q;
        REG_MODE:    rd_data[N-1:0] = mode_q;
        REG_ID: begin
          rd_data[31]  = id_valid;
          rd_data[2:0] = id_index;
        end
        default:     rd_data = '0;
      endcase
    end
  end

  // State registers; reset discards all pending events and configuration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      prev_q    <= '0;
      hwint_q   <= '0;
      intreq_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      prev_q    <= prev_d;
      hwint_q   <= hwint_d;
      intreq_q  <= intreq_d;
    end
  end

  assign bus.DataOut = rd_data;
  assign HWInt       = hwint_q;
  assign IntReq      = intreq_q;

endmodule : irq_collector

// File: tb/tb_irq_collector.sv
// Self-checking bench for irq_collector: directed steps from the register
// behaviour followed by a randomized run, compared against a line-by-line
// behavioural model of the collector.
module tb_irq_collector;

  localparam int          N    = 6;
  localparam logic [31:0] BASE = 32'h0000_7f20;

  logic         clk;
  logic         reset;
  logic [N-1:0] dev;
  logic [5:0]   hwint;
  logic         intreq;

  irq_collector_if bus_if ();

  irq_collector #(.N(N), .BASE(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .DevIRQ (dev),
    .HWInt  (hwint),
    .IntReq (intreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model state, one bit per line.
  bit [5:0] m_pend, m_mask, m_mode, m_prev, m_hw;
  bit       m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_mode = '0; m_prev = '0; m_hw = '0; m_irq = 0;
  endtask

  function automatic int reg_of(input logic [31:0] a);
    if (a >= BASE && a < BASE + 32'd16) return int'((a - BASE) / 4);
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int r;
    r = reg_of(a);
    case (r)
      0: return {26'd0, m_pend};
      1: return {26'd0, m_mask};
      2: return {26'd0, m_mode};
      3: begin
        for (int i = 0; i < N; i++)
          if (m_pend[i] && m_mask[i]) return 32'h8000_0000 + i;
        return 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge of the model, using the inputs the bench is driving.
  task automatic model_update();
    bit [5:0] np, nm, nd;
    int       r;
    if (!reset) begin
      model_reset();
      return;
    end
    r  = bus_if.WE ? reg_of(bus_if.Addr) : -1;
    nm = (r == 1) ? bus_if.DataIn[5:0] : m_mask;
    nd = (r == 2) ? bus_if.DataIn[5:0] : m_mode;
    for (int i = 0; i < N; i++) begin
      bit fire;
      fire = m_mode[i] ? (dev[i] && !m_prev[i]) : dev[i];
      if (fire)                               np[i] = 1;
      else if (r == 0 && bus_if.DataIn[i])    np[i] = 0;
      else                                    np[i] = m_pend[i];
    end
    m_pend = np;
    m_mask = nm;
    m_mode = nd;
    m_prev = dev;
    m_hw   = np & nm;
    m_irq  = (m_hw != 0);
  endtask

  task automatic drive(input logic [5:0] d, input logic [31:0] a, input logic w, input logic [31:0] din);
    dev           = d;
    bus_if.Addr   = a;
    bus_if.WE     = w;
    bus_if.DataIn = din;
  endtask

  // Advance one clock, then compare the registered outputs on the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check({tag, ".hwint"},  {26'd0, hwint},  {26'd0, m_hw});
    check({tag, ".intreq"}, {31'd0, intreq}, {31'd0, m_irq});
  endtask

  task automatic wr(input logic [5:0] d, input logic [31:0] a, input logic [31:0] din, input string tag);
    drive(d, a, 1'b1, din);
    cycle(tag);
    bus_if.WE = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input string tag);
    bus_if.Addr = a;
    bus_if.WE   = 1'b0;
    #1;
    check(tag, bus_if.DataOut, model_read(a));
  endtask

  initial begin
    logic [31:0] addrs [6];
    addrs[0] = BASE; addrs[1] = BASE + 4; addrs[2] = BASE + 8;
    addrs[3] = BASE + 12; addrs[4] = 32'h0000_7f10; addrs[5] = 32'h0000_7f30;

    reset = 1'b0;
    model_reset();
    drive(6'h3F, 32'd0, 1'b0, 32'd0);

    // Reset held: inputs toggling must not reach any state.
    cycle("rst0");
    cycle("rst1");
    check("rst.hwint", {26'd0, hwint}, 32'd0);
    rd(BASE,      "rst.pending");
    rd(BASE + 4,  "rst.mask");
    rd(BASE + 8,  "rst.mode");
    rd(BASE + 12, "rst.id");

    @(negedge clk);
    reset = 1'b1;
    drive(6'h00, 32'd0, 1'b0, 32'd0);
    cycle("idle");

    // Masked capture, then enabling the line.
    dev = 6'h04; cycle("mc.pulse");
    dev = 6'h00; cycle("mc.quiet");
    rd(BASE, "mc.pending");
    check("mc.pending_val", bus_if.DataOut, 32'h4);
    check("mc.hw_masked", {26'd0, hwint}, 32'd0);
    wr(6'h00, BASE + 4, 32'h4, "mc.wmask");
    check("mc.hw_val", {26'd0, hwint}, 32'h04);
    check("mc.irq_val", {31'd0, intreq}, 32'd1);
    rd(BASE + 12, "mc.id");
    check("mc.id_val", bus_if.DataOut, 32'h8000_0002);

    // W1C and set-beats-clear.
    wr(6'h00, BASE + 4, 32'h3F, "w1c.mask");
    dev = 6'h01; cycle("w1c.set0");
    dev = 6'h00; cycle("w1c.quiet");
    rd(BASE, "w1c.p05");
    check("w1c.p05_val", bus_if.DataOut, 32'h05);
    wr(6'h00, BASE, 32'h01, "w1c.clr0");
    rd(BASE, "w1c.p04");
    check("w1c.p04_val", bus_if.DataOut, 32'h04);
    wr(6'h00, BASE + 8, 32'h04, "w1c.mode");
    wr(6'h04, BASE, 32'h04, "w1c.race");
    rd(BASE, "w1c.race_rd");
    check("w1c.race_val", bus_if.DataOut, 32'h04);
    wr(6'h00, BASE, 32'h3F, "w1c.clrall");
    rd(BASE, "w1c.empty");

    // Edge versus level on lines 0 and 1.
    wr(6'h00, BASE + 8, 32'h01, "el.mode");
    dev = 6'h03;
    for (int i = 0; i < 10; i++) cycle("el.hold");
    rd(BASE, "el.held");
    wr(6'h03, BASE, 32'h03, "el.clr");
    rd(BASE, "el.after_clr");
    check("el.after_clr_val", bus_if.DataOut, 32'h02);
    cycle("el.stay");
    rd(BASE, "el.stay_rd");
    check("el.stay_val", bus_if.DataOut, 32'h02);
    dev = 6'h02; cycle("el.drop");
    dev = 6'h03; cycle("el.raise");
    rd(BASE, "el.raised");
    check("el.raised_val", bus_if.DataOut, 32'h03);
    wr(6'h03, BASE, 32'h01, "el.clr0");
    cycle("el.once");
    rd(BASE, "el.once_rd");
    check("el.once_val", bus_if.DataOut, 32'h02);

    // Priority encoder and address decode.
    wr(6'h00, BASE + 8, 32'h00, "pd.mode");
    wr(6'h00, BASE, 32'h3F, "pd.clr");
    dev = 6'h30; cycle("pd.set");
    dev = 6'h00;
    wr(6'h00, BASE + 4, 32'h20, "pd.mask");
    rd(BASE + 12, "pd.id");
    check("pd.id_val", bus_if.DataOut, 32'h8000_0005);
    wr(6'h00, 32'h0000_7f14, 32'h0, "pd.timer_wr");
    rd(BASE + 4, "pd.mask_kept");
    check("pd.mask_kept_val", bus_if.DataOut, 32'h20);
    rd(32'h0000_7f30, "pd.outside");
    check("pd.outside_val", bus_if.DataOut, 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [5:0]  d;
      logic [31:0] a;
      d = 6'($urandom);
      a = addrs[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) wr(d, a, $urandom, "rnd.wr");
      else begin
        drive(d, a, 1'b0, 32'd0);
        cycle("rnd.idle");
      end
      rd(addrs[$urandom_range(0, 5)], "rnd.rd");
    end

    // Asynchronous reset between edges.
    wr(6'h00, BASE + 8, 32'h00, "ar.mode");
    wr(6'h00, BASE + 4, 32'h3F, "ar.mask");
    dev = 6'h3F; cycle("ar.fill");
    rd(BASE, "ar.full");
    check("ar.full_val", bus_if.DataOut, 32'h3F);
    check("ar.irq_high", {31'd0, intreq}, 32'd1);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("ar.hw_now", {26'd0, hwint}, 32'd0);
    check("ar.irq_now", {31'd0, intreq}, 32'd0);
    dev = 6'h00;
    rd(BASE,     "ar.pending");
    rd(BASE + 4, "ar.mask_rd");
    @(negedge clk);
    reset = 1'b1;
    cycle("ar.release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_irq_collector
